bcd_sub_sequencer: RTL and testbench

BCD_SUB_SEQUENCER -- requirements
Module: bcd_sub_sequencer

---
 rtl/bcd_sub_sequencer.sv | 171 +++++++++++++++++
 tb/tb_bcd_sub_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sub_sequencer.sv
// Multi-digit BCD subtractor sequencer: walks one digit per cycle through an
// external digit subtractor, with optional ten's-complement-to-magnitude pass.
module bcd_sub_sequencer #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  signMode,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [3:0]            digA,
  output logic [3:0]            digB,
  output logic                  digBorrowIn,
  input  logic [3:0]            digResult,
  input  logic                  digBorrowOut,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  negative,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  // Handshake: start is sampled only while idle (busy=0); each accepted start
  // yields exactly one single-cycle done pulse, after which result/negative/
  // error stay valid until the next done or reset.

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SUB   = 3'd2,
    S_NEG   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DIGITS-1:0][3:0] a_q, b_q, work_q, work_next;
  logic                   sign_mode_q;
  logic [IW-1:0]          idx_q;
  logic                   borrow_q;
  logic                   neg_q;
  logic                   bad_digit;
  logic                   last_digit;

  assign last_digit = (idx_q == LAST_IDX);

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[i] > 4'd9 || b_q[i] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Working value as it will look after the current digit is written back.
  always_comb begin
    work_next        = work_q;
    work_next[idx_q] = digResult;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = bad_digit ? S_DONE : S_SUB;
      S_SUB: begin
        if (last_digit) state_d = (digBorrowOut && sign_mode_q) ? S_NEG : S_DONE;
      end
      S_NEG:   if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    digA        = 4'd0;
    digB        = 4'd0;
    digBorrowIn = 1'b0;
    case (state_q)
      S_SUB: begin
        digA        = a_q[idx_q];
        digB        = b_q[idx_q];
        digBorrowIn = borrow_q;
      end
      S_NEG: begin
        digB        = work_q[idx_q];
        digBorrowIn = borrow_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      sign_mode_q <= 1'b0;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      neg_q       <= 1'b0;
      result      <= '0;
      negative    <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q         <= a;
            b_q         <= b;
            sign_mode_q <= signMode;
            work_q      <= '0;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            neg_q       <= 1'b0;
          end
        end
        S_CHECK: begin
          if (bad_digit) begin
            result   <= '0;
            negative <= 1'b0;
            error    <= 1'b1;
          end
        end
        S_SUB: begin
          work_q[idx_q] <= digResult;
          if (last_digit) begin
            neg_q    <= digBorrowOut;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            if (!(digBorrowOut && sign_mode_q)) begin
              result   <= work_next;
              negative <= digBorrowOut;
              error    <= 1'b0;
            end
          end else begin
            idx_q    <= idx_q + 1'b1;
            borrow_q <= digBorrowOut;
          end
        end
        S_NEG: begin
          // Final borrow of the negation pass carries no information.
          work_q[idx_q] <= digResult;
          if (last_digit) begin
            result   <= work_next;
            negative <= neg_q;
            error    <= 1'b0;
          end else begin
            idx_q    <= idx_q + 1'b1;
            borrow_q <= digBorrowOut;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_sequencer.sv
// Directed + random bench for bcd_sub_sequencer with a behavioural digit
// subtractor and a decimal reference model feeding an expected queue.
module tb_bcd_sub_sequencer;

  localparam int D = 3;
  localparam int W = 22; // {latency[7:0], error, negative, result[11:0]}

  logic           clk;
  logic           rstN;
  logic           start;
  logic           signMode;
  logic [4*D-1:0] a, b;
  logic [3:0]     digA, digB, digResult;
  logic           digBorrowIn, digBorrowOut;
  logic           busy, done, negative, error;
  logic [4*D-1:0] result;
  logic [2:0]     dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;
  bit dig_active;
  bit busy_drop;
  bit after_done = 0;
  logic [4*D-1:0] last_result;

  bcd_sub_sequencer #(.DIGITS(D)) dut (
    .clk(clk), .rstN(rstN), .start(start), .signMode(signMode),
    .a(a), .b(b), .digA(digA), .digB(digB), .digBorrowIn(digBorrowIn),
    .digResult(digResult), .digBorrowOut(digBorrowOut),
    .busy(busy), .done(done), .result(result), .negative(negative),
    .error(error), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External single-digit BCD subtractor
  logic [4:0] dig_t;
  always_comb begin
    dig_t        = {1'b0, digA} - {1'b0, digB} - {4'd0, digBorrowIn};
    digBorrowOut = dig_t[4];
    digResult    = dig_t[4] ? (dig_t[3:0] + 4'd10) : dig_t[3:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [4*D-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] int_to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4*D-1:0] rand_bcd();
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [4*D-1:0] ma, input logic [4*D-1:0] mb,
                                         input logic sm);
    bit err = 0;
    int diff, lat;
    logic neg;
    logic [4*D-1:0] res;
    for (int i = 0; i < D; i++)
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) err = 1;
    if (err) return {8'd2, 1'b1, 1'b0, {(4*D){1'b0}}};
    diff = bcd_to_int(ma) - bcd_to_int(mb);
    neg  = (diff < 0);
    if (neg && sm) begin
      res = int_to_bcd(-diff);
      lat = 2 * D + 2;
    end else begin
      res = int_to_bcd(neg ? diff + 1000 : diff);
      lat = D + 2;
    end
    return {8'(lat), 1'b0, neg, res};
  endfunction

  // Driver: presents one start in an IDLE cycle and queues its expectation.
  task automatic issue(input logic [4*D-1:0] ia, input logic [4*D-1:0] ib, input logic sm);
    @(negedge clk);
    if (after_done) begin
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
      after_done = 0;
    end
    a = ia; b = ib; signMode = sm; start = 1'b1;
    exp_q.push_back(model(ia, ib, sm));
    @(posedge clk);
    #1;
    t_start = cyc;
    start = 1'b0;
  endtask

  // Scoreboard: waits (bounded) for done and compares against the queue head.
  task automatic wait_done(input string tag);
    logic [W-1:0] e;
    bit got = 0;
    int lat;
    dig_active = 0;
    busy_drop  = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (digA != 4'd0 || digB != 4'd0 || digBorrowIn) dig_active = 1;
      if (done) got = 1;
      else if (!busy) busy_drop = 1;
    end
    lat = cyc - t_start + 1;
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_result"},   {20'd0, result}, {20'd0, e[11:0]});
    check({tag, "_negative"}, {31'd0, negative}, {31'd0, e[12]});
    check({tag, "_error"},    {31'd0, error}, {31'd0, e[13]});
    check({tag, "_latency"},  lat, {24'd0, e[21:14]});
    check({tag, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
    last_result = e[11:0];
    after_done = 1;
  endtask

  initial begin
    bit done_seen;
    rstN = 1'b0; start = 1'b0; signMode = 1'b0; a = '0; b = '0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {20'd0, result}, 32'd0);
    check("rst_flags", {30'd0, negative, error}, 32'd0);
    check("rst_dig", {23'd0, digA, digB, digBorrowIn}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    issue(12'h345, 12'h123, 1'b0); wait_done("p345m123");
    check("dig_lines_used", {31'd0, dig_active}, 32'd1);
    issue(12'h123, 12'h345, 1'b0); wait_done("p123m345_raw");
    issue(12'h123, 12'h345, 1'b1); wait_done("p123m345_mag");
    issue(12'h000, 12'h999, 1'b1); wait_done("p000m999");
    issue(12'h000, 12'h000, 1'b1); wait_done("p000m000");
    issue(12'h3A5, 12'h100, 1'b0); wait_done("bad_digit");
    check("bad_no_dig_cycles", {31'd0, dig_active}, 32'd0);

    // Start pulsed mid-SUB must be ignored.
    issue(12'h876, 12'h123, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 12'h999; b = 12'h000; signMode = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("start_ignored");
    // Back-to-back: start in the IDLE cycle right after done.
    issue(12'h210, 12'h987, 1'b1); wait_done("back_to_back");

    for (int k = 0; k < 6; k++) begin
      issue(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
      wait_done("rand");
    end

    // Hold check: outputs persist through idle cycles.
    repeat (5) @(negedge clk);
    check("result_hold", {20'd0, result}, {20'd0, last_result});

    // Reset in the middle of the negation pass.
    issue(12'h123, 12'h345, 1'b1);
    repeat (5) @(negedge clk);
    check("in_neg_state", {29'd0, dbg_state}, 32'd3);
    rstN = 1'b0;
    #1;
    void'(exp_q.pop_front());
    after_done = 0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_outputs", {18'd0, result, negative, error}, 32'd0);
    check("midrst_dig", {23'd0, digA, digB, digBorrowIn}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    rstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("midrst_no_done", {31'd0, done_seen}, 32'd0);
    issue(12'h500, 12'h001, 1'b0); wait_done("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
